// File: rtl/nq_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package nq_fetch_pkg;

    localparam int unsigned ADDR_W        = 16;
    localparam int unsigned INST_W        = 32;
    localparam int unsigned DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalted
    } state_t;

    // One buffered instruction together with the address it came from.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH entries of {pc, inst}, synchronous flush, head output.
module fetch_fifo
    import nq_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output entry_t                   head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    entry_t                 mem_q [DEPTH];
    logic [PTR_W-1:0]       wptr_q;
    logic [PTR_W-1:0]       rptr_q;
    logic [$clog2(DEPTH):0] count_q;

    // Pointer and occupancy bookkeeping; flush wins over push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    // Storage write; contents need no reset because count gates the head.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wptr_q] <= push_data;
    end

    // Head reads as zero when empty so decode sees clean values out of reset.
    always_comb begin
        count = count_q;
        head  = (count_q != '0) ? mem_q[rptr_q] : '0;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one-deep memory pipeline feeding a small decode buffer.
module fetch_unit
    import nq_fetch_pkg::*;
#(
    parameter int unsigned       DEPTH    = DEPTH_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [INST_W-1:0] mem_inst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              dec_valid,
    output logic [INST_W-1:0] dec_inst,
    output logic [ADDR_W-1:0] dec_pc,
    input  logic              dec_ready
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;

    logic              push, pop, replay, issue;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occupancy;
    entry_t            push_data, head;

    // Fetch state, address and in-flight tracking registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

    // Issue, response handling and state transitions; redirect overrides everything.
    always_comb begin
        push      = inflight_q && mem_valid && !redirect;
        replay    = inflight_q && !mem_valid && !redirect;
        pop       = dec_valid && dec_ready && !redirect;
        // Reserve a slot for the outstanding response; a same-cycle pop is not credited.
        occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
        issue     = (state_q == StRun) && !redirect && !replay &&
                    (occupancy < (CNT_W + 1)'(DEPTH));
        push_data = '{pc: inflight_pc_q, inst: mem_inst};

        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = 1'b0;

        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end else if (replay) begin
            fetch_pc_d = inflight_pc_q;
        end else if (issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + 1'b1;
        end

        if (redirect) begin
            state_d = StRun;
        end else begin
            unique case (state_q)
                StIdle:   state_d = StRun;
                StRun:    if (halt) state_d = StHalted;
                StHalted: if (!halt) state_d = StRun;
                default:  state_d = StIdle;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect),
        .count     (count),
        .head      (head)
    );

    // Memory address and decode-side outputs.
    always_comb begin
        mem_addr  = fetch_pc_q;
        dec_valid = (count != '0);
        dec_inst  = head.inst;
        dec_pc    = head.pc;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table, corner sequences, random stream.
module tb_fetch_unit;

    localparam int unsigned DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_addr;
    logic        mem_valid = 1'b1;
    logic [31:0] mem_inst = '0;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [15:0] dec_pc;
    logic        dec_ready;

    int checks = 0;
    int errors = 0;

    // Reference: the next pc decode must see, and every pc popped so far.
    logic [15:0] exp_pc;
    logic [15:0] popped[$];

    // Memory fault injection and random-valid controls.
    int          drop_req_id  = 0;
    int          drop_used_id = 0;
    logic [15:0] drop_addr    = 16'hFFFF;
    logic        rand_valid   = 1'b0;
    int          addr_hits;

    fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_addr    (mem_addr),
        .mem_valid   (mem_valid),
        .mem_inst    (mem_inst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .dec_valid   (dec_valid),
        .dec_inst    (dec_inst),
        .dec_pc      (dec_pc),
        .dec_ready   (dec_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [15:0] a);
        if (a == 16'h0001) return 32'h4820_4001;
        return {~a, a};
    endfunction

    // Instruction memory: one-cycle registered read of whatever address is presented.
    always @(posedge clk) begin
        mem_inst <= inst_of(mem_addr);
        if (drop_req_id != drop_used_id && mem_addr == drop_addr) begin
            mem_valid    <= 1'b0;
            drop_used_id <= drop_req_id;
        end else begin
            mem_valid <= rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // One cycle: score any pop against the model, advance the clock, check redirect effects.
    task automatic tick();
        logic        was_redir;
        logic [15:0] rpc;
        was_redir = redirect && !rst;
        rpc       = redirect_pc;
        if (!rst && !redirect && dec_valid && dec_ready) begin
            check("dec_pc order", {32'd0, dec_pc}, {32'd0, exp_pc});
            check("dec_inst data", {16'd0, dec_inst}, {16'd0, inst_of(exp_pc)});
            popped.push_back(dec_pc);
            exp_pc = exp_pc + 16'd1;
        end
        if (was_redir) exp_pc = rpc;
        @(posedge clk);
        #1;
        if (was_redir) begin
            check("dec_valid after redirect", {47'd0, dec_valid}, 48'd0);
            check("mem_addr after redirect", {32'd0, mem_addr}, {32'd0, rpc});
        end
        if (mem_addr == drop_addr) addr_hits++;
    endtask

    task automatic do_redirect(input logic [15:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        tick();
        redirect    = 1'b0;
    endtask

    typedef struct {
        logic [15:0] target;
        logic        has_drop;
        logic [15:0] drop_at;
        logic [15:0] exp0;
        logic [15:0] exp1;
        logic [15:0] exp2;
    } vec_t;

    // Watchdog so a stuck design can never hang the run.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[4];
        logic [15:0] hold_pc;
        logic [31:0] hold_inst;
        logic [15:0] hold_addr;
        int          n;

        vecs[0] = '{target: 16'h0004, has_drop: 1'b1, drop_at: 16'h0005,
                    exp0: 16'h0004, exp1: 16'h0005, exp2: 16'h0006};
        vecs[1] = '{target: 16'hFFFF, has_drop: 1'b0, drop_at: 16'h0000,
                    exp0: 16'hFFFF, exp1: 16'h0000, exp2: 16'h0001};
        vecs[2] = '{target: 16'h00FE, has_drop: 1'b1, drop_at: 16'h00FF,
                    exp0: 16'h00FE, exp1: 16'h00FF, exp2: 16'h0100};
        vecs[3] = '{target: 16'h1234, has_drop: 1'b0, drop_at: 16'h0000,
                    exp0: 16'h1234, exp1: 16'h1235, exp2: 16'h1236};

        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        halt        = 1'b0;
        dec_ready   = 1'b0;
        exp_pc      = RESET_PC;
        addr_hits   = 0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("reset mem_addr", {32'd0, mem_addr}, {32'd0, RESET_PC});
        check("reset dec_valid", {47'd0, dec_valid}, 48'd0);
        check("reset dec_pc", {32'd0, dec_pc}, 48'd0);
        check("reset dec_inst", {16'd0, dec_inst}, 48'd0);

        // Release: one idle cycle, then addresses 0 and 1 back to back.
        rst       = 1'b0;
        dec_ready = 1'b1;
        check("idle mem_addr", {32'd0, mem_addr}, 48'd0);
        tick();
        check("first issue addr", {32'd0, mem_addr}, 48'd0);
        tick();
        check("second issue addr", {32'd0, mem_addr}, 48'd1);
        check("no early dec_valid", {47'd0, dec_valid}, 48'd0);
        tick();
        check("first dec_valid", {47'd0, dec_valid}, 48'd1);
        check("first dec_pc", {32'd0, dec_pc}, 48'd0);
        tick();
        check("addr1 dec_pc", {32'd0, dec_pc}, 48'd1);
        check("addr1 dec_inst", {16'd0, dec_inst}, {16'd0, 32'h4820_4001});
        tick();

        // Table: redirect target, optional dropped response, first three delivered pcs.
        for (int i = 0; i < 4; i++) begin
            drop_addr = vecs[i].drop_at;
            if (vecs[i].has_drop) drop_req_id++;
            do_redirect(vecs[i].target);
            popped.delete();
            addr_hits = (mem_addr == drop_addr) ? 1 : 0;
            for (int k = 0; k < 20; k++) tick();
            if (popped.size() < 3) begin
                check("table deliveries", 48'(popped.size()), 48'd3);
            end else begin
                check("table pc0", {32'd0, popped[0]}, {32'd0, vecs[i].exp0});
                check("table pc1", {32'd0, popped[1]}, {32'd0, vecs[i].exp1});
                check("table pc2", {32'd0, popped[2]}, {32'd0, vecs[i].exp2});
            end
            if (vecs[i].has_drop) check("replay addr seen twice", 48'(addr_hits), 48'd2);
        end
        drop_addr = 16'hFFFF;

        // Steady state: one delivery per cycle.
        popped.delete();
        for (int k = 0; k < 10; k++) tick();
        check("throughput", 48'(popped.size()), 48'd10);

        // Decode stall: buffer fills to DEPTH, issue stops, head holds.
        dec_ready = 1'b0;
        hold_pc   = dec_pc;
        hold_inst = dec_inst;
        hold_addr = '0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("stall dec_pc stable", {32'd0, dec_pc}, {32'd0, hold_pc});
            check("stall dec_inst stable", {16'd0, dec_inst}, {16'd0, hold_inst});
            if (k == 7) hold_addr = mem_addr;
        end
        check("stall issue stopped", {32'd0, mem_addr}, {32'd0, hold_addr});
        check("stall depth", {32'd0, mem_addr}, {32'd0, hold_pc + 16'(DEPTH)});
        dec_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("drain no gap", {47'd0, dec_valid}, 48'd1);
            tick();
        end

        // Redirect with three buffered and one in flight.
        dec_ready = 1'b0;
        do_redirect(16'h0300);
        for (int k = 0; k < 4; k++) tick();
        check("pre-redirect buffered", {47'd0, dec_valid}, 48'd1);
        check("pre-redirect head", {32'd0, dec_pc}, {32'd0, 16'h0300});
        do_redirect(16'h0020);
        dec_ready = 1'b1;
        popped.delete();
        for (int k = 0; k < 6; k++) tick();
        if (popped.size() == 0) check("post-redirect deliveries", 48'd0, 48'd1);
        else check("post-redirect first pc", {32'd0, popped[0]}, {32'd0, 16'h0020});

        // Halt: fetch address freezes, buffer drains, then fetch resumes in order.
        halt = 1'b1;
        tick();
        tick();
        hold_addr = mem_addr;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("halt addr frozen", {32'd0, mem_addr}, {32'd0, hold_addr});
        end
        check("halt drained", {47'd0, dec_valid}, 48'd0);
        halt = 1'b0;
        popped.delete();
        for (int k = 0; k < 6; k++) tick();
        check("resume after halt", {47'd0, popped.size() > 0}, 48'd1);

        // Random stream against the ordering model.
        rand_valid = 1'b1;
        popped.delete();
        n = 0;
        for (int k = 0; k < 1500; k++) begin
            dec_ready   = 1'($urandom_range(0, 1));
            redirect    = ($urandom_range(0, 49) == 0);
            redirect_pc = 16'($urandom);
            if (n > 0) begin
                n--;
                halt = 1'b1;
            end else begin
                halt = 1'b0;
                if ($urandom_range(0, 39) == 0) n = int'($urandom_range(1, 6));
            end
            tick();
        end
        redirect   = 1'b0;
        halt       = 1'b0;
        rand_valid = 1'b0;
        check("random progress", {47'd0, popped.size() > 100}, 48'd1);

        // Asynchronous reset mid-stream.
        dec_ready = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        dec_ready = 1'b0;
        tick();
        check("pre-reset dec_valid", {47'd0, dec_valid}, 48'd1);
        rst = 1'b1;
        #1;
        check("async reset dec_valid", {47'd0, dec_valid}, 48'd0);
        check("async reset mem_addr", {32'd0, mem_addr}, {32'd0, RESET_PC});
        @(posedge clk);
        #1;
        rst       = 1'b0;
        dec_ready = 1'b1;
        exp_pc    = RESET_PC;
        check("post-reset mem_addr", {32'd0, mem_addr}, {32'd0, RESET_PC});
        popped.delete();
        for (int k = 0; k < 8; k++) tick();
        if (popped.size() == 0) check("post-reset deliveries", 48'd0, 48'd1);
        else check("post-reset first pc", {32'd0, popped[0]}, {32'd0, RESET_PC});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4: number of instruction buffer entries, power of two, minimum 2.
REQ-002 Parameter RESET_PC, default 16'h0000: first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 mem_addr  output  16  word address presented to the instruction memory; the memory samples it each rising edge.
REQ-006 mem_valid  input  1  memory response qualifier, aligned with mem_inst.
REQ-007 mem_inst  input  32  instruction for the address sampled on the previous edge.
REQ-008 redirect  input  1  branch/jump redirect request, one-cycle pulse.
REQ-009 redirect_pc  input  16  redirect target; valid while redirect=1.
REQ-010 halt  input  1  stop issuing new fetches while high.
REQ-011 dec_valid  output  1  buffer head holds an instruction for decode.
REQ-012 dec_inst  output  32  instruction at buffer head.
REQ-013 dec_pc  output  16  address of dec_inst.
REQ-014 dec_ready  input  1  decode accepts the head this cycle.

Function
REQ-015 States: IDLE, RUN, HALTED; IDLE lasts exactly one cycle after reset release, then goes to RUN.
REQ-016 mem_addr = fetch_pc combinationally in every state.
REQ-017 Issue in a cycle iff state=RUN, redirect=0, and count+inflight < DEPTH (a same-cycle pop is not credited).
REQ-018 On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
REQ-019 No issue: inflight<=0, fetch_pc unchanged.
REQ-020 Response cycle (inflight=1, mem_valid=1, no redirect): push {inflight_pc, mem_inst} at the buffer tail.
REQ-021 Response cycle with mem_valid=0: drop the data; fetch_pc<=inflight_pc (replay); no issue in that cycle.
REQ-022 Latency: address issued in cycle N has dec_valid=1 with that instruction in cycle N+2 at the earliest.
REQ-023 Steady state with dec_ready=1 and mem_valid=1: one instruction delivered per cycle.
REQ-024 Pop when dec_valid and dec_ready are both high; push and pop in the same cycle leave count unchanged.
REQ-025 dec_valid = (count != 0); dec_inst and dec_pc are stable while dec_valid=1 and dec_ready=0.
REQ-026 redirect=1 has priority over push, pop, issue, and halt: buffer emptied, inflight<=0 (pending response discarded), fetch_pc<=redirect_pc, state<=RUN.
REQ-027 After redirect, mem_addr=redirect_pc in the next cycle; no pre-redirect instruction ever reaches decode.
REQ-028 halt=1 in RUN: go to HALTED; no further issues; the in-flight response is still pushed; the buffer continues to drain.
REQ-029 HALTED returns to RUN when halt falls; fetch resumes at fetch_pc.
REQ-030 count never exceeds DEPTH; a push with a full buffer cannot occur by construction (REQ-017).

Reset
REQ-031 While rst=1: fetch_pc=RESET_PC, inflight=0, inflight_pc=0, count=0, read/write pointers=0, state=IDLE, dec_valid=0, dec_inst=0, dec_pc=0, mem_addr=RESET_PC.
REQ-032 Reset asserted mid-operation discards all buffered and in-flight instructions immediately, without waiting for a clock edge.

Structure
REQ-033 Shared package nq_fetch_pkg holds the state enum, ADDR_W=16, INST_W=32, and the default DEPTH.
REQ-034 Sub-module fetch_fifo implements the DEPTH x 48-bit buffer ({pc, inst}) with push, pop, flush, count, and head outputs.

Verification
REQ-035 Reset release with the memory returning 32'h4820_4001 at address 1: mem_addr is 0 then 1, consecutively; dec_pc=1 and dec_inst=32'h4820_4001 appear two cycles after address 1 is issued.
REQ-036 dec_ready=0 for 10 cycles: exactly 4 entries buffered, issue stops, and dec_inst holds stable; after dec_ready=1, the pcs pop in order with no gap or duplicate.
REQ-037 Redirect to 16'h0020 while 3 entries are buffered and one is in flight: dec_valid=0 next cycle; the next delivered dec_pc=16'h0020.
REQ-038 mem_valid=0 for one response at address 5: address 5 is re-presented; decode receives 4, 5, 6 with no duplicates.
REQ-039 fetch_pc=16'hFFFF: dec_pc sequence is FFFF then 0000.
REQ-040 rst pulsed mid-stream while dec_valid=1: dec_valid falls asynchronously; after release, the first fetch is RESET_PC.
